mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised iterative multiply/divide unit, the sequential successor to the single-cycle ALU. Executes signed/unsigned multiply and divide one bit per cycle, writing a double-width result into HI/LO registers. Sits beside the ALU in execute; the hazard unit stalls on `busy`, and the pipeline squashes in-flight operations with `flush`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `CLK`  in  1  rising-edge clock.
- `nRST`  in  1  asynchronous active-low reset.
- `start`  in  1  request; accepted only on a cycle where `busy`=0.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `op1`  in  WIDTH  multiplicand/dividend; sampled with `start`.
- `op2`  in  WIDTH  multiplier/divisor; sampled with `start`.
- `flush`  in  1  abort the in-flight operation.
- `busy`  out  1  high from the cycle after acceptance until the result is written.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `hi`  out  WIDTH  multiply upper half; divide remainder.
- `lo`  out  WIDTH  multiply lower half; divide quotient.
- `flag_z`  out  1  `lo`==0; updated with `done`.
- `flag_dz`  out  1  the last divide had a zero divisor; updated with `done`.

## Operation
- Reset: FSM goes to IDLE. `busy`, `done`, `flag_z`, `flag_dz` are 0. `hi` and `lo` are 0. Iteration counter is 0.
- FSM states and transitions:
  - IDLE: `start`=1 and `flush`=0 → PREP, latching `op`, `op1`, `op2`.
  - PREP: convert operands to magnitudes for the signed ops (MULT, DIV); record result signs.
    - Divide with `op2`==0 → FIX.
    - Otherwise → RUN, counter cleared.
  - RUN, multiply: shift-add, one multiplier bit per cycle.
  - RUN, divide: restoring shift-subtract, one quotient bit per cycle.
  - RUN exit: → FIX after WIDTH cycles (counter reaches WIDTH-1).
  - FIX: apply signs, write `hi`/`lo`/flags → IDLE.
- Multiply result: the full 2·WIDTH product. `hi` gets the upper WIDTH bits, `lo` the lower WIDTH bits.
  - MULT is two's-complement.
  - MULTU is unsigned.
- Divide result: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: `lo` = all ones, `hi` = `op1` unchanged, `flag_dz`=1.
  - `flag_dz` is cleared by any other completed operation.
- Signed overflow (DIV of most-negative value by −1): `lo` = most-negative value, `hi`=0, `flag_dz`=0.
- `start` while `busy`=1 is ignored; the operands are not re-latched.
- `flush`=1 in any non-IDLE state → IDLE at the next edge.
  - No `done` pulse; `hi`/`lo`/flags keep their prior values.
- `flush` and `start` together in IDLE: `flush` wins and the request is dropped.
- `start` in the cycle `done`=1: accepted, because `busy`=0 in that cycle.
- `nRST` low mid-operation: immediate return to reset values; the operation is lost.

## Timing
- Let `start` be accepted at edge k.
  - `busy`=1 in cycles k+1 … k+WIDTH+2.
  - `hi`/`lo`/flags are updated at edge k+WIDTH+2.
  - `done`=1 and `busy`=0 in the cycle following edge k+WIDTH+2.
- Normal latency: WIDTH+2 cycles (34 for WIDTH=32).
- Divide-by-zero latency: 2 cycles (PREP → FIX).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `MDU_EARLY_OUT_EN`.
- Defined:
  - Multiply RUN exits to FIX after the first step that leaves the remaining multiplier magnitude zero.
  - Minimum is one RUN cycle.
  - Latency = 2 + (index of MSB of |op2|) + 1, with |op2|=0 counting as 1.
  - Divide latency is unchanged.
- Undefined: every multiply runs exactly WIDTH RUN cycles.
- Results are identical in both configurations.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` 34 cycles after acceptance, `busy` high for the 34 cycles before it (no macro).
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `flag_z`=0.
- DIV −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; then DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 100 ÷ 0 → `done` after 2 cycles, `lo`=0xFFFFFFFF, `hi`=0x64, `flag_dz`=1; following DIVU 0 ÷ 5 → `lo`=0, `hi`=0, `flag_z`=1, `flag_dz`=0.
- Complete MULTU 4 × 5 (`lo`=0x14), then start MULTU 6 × 7 and assert `flush` 10 cycles after acceptance:
  - `busy`=0 the next cycle, no `done`, `lo` stays 0x14.
  - A `start` asserted simultaneously with a second `flush` in IDLE is dropped.
  - A later MULTU 6 × 7 returns `lo`=0x2A.
- MULTU 3 × 5 with `MDU_EARLY_OUT_EN` → `lo`=15, `done` after 5 cycles; without the macro → `done` after 34 cycles. Also check back-to-back `start` on the `done` cycle is accepted.

Source files
------------

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit: iterative signed/unsigned multiply/divide into HI/LO, 1 bit/cycle.
// Optional macro MDU_EARLY_OUT_EN: multiplies stop once the multiplier is spent.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             flag_z,
  output logic             flag_dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t state, state_nx;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;   // product, or remainder in the low half
  logic [2*WIDTH-1:0] opa;   // shifted multiplicand, or divisor in the low half
  logic [WIDTH-1:0]   opb;   // remaining multiplier, or dividend/quotient
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r, dz_q;

  logic               is_div, a_neg, b_neg, div_zero, run_last, q_bit;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [WIDTH:0]     shifted, diff;
  logic [2*WIDTH-1:0] acc_add, prod_fix;

  assign is_div   = op_q[1];
  assign a_neg    = op_q[0] & a_q[WIDTH-1];
  assign b_neg    = op_q[0] & b_q[WIDTH-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  assign div_zero = (b_q == '0);

  // Restoring divide step: bring in the next dividend bit and trial-subtract.
  assign shifted  = {acc[WIDTH-1:0], opb[WIDTH-1]};
  assign diff     = shifted - {1'b0, opa[WIDTH-1:0]};
  assign q_bit    = ~diff[WIDTH];

  assign acc_add  = acc + (opb[0] ? opa : '0);

  assign prod_fix = neg_q ? -acc : acc;
  assign quot_fix = neg_q ? -opb : opb;
  assign rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

`ifdef MDU_EARLY_OUT_EN
  assign run_last = (cnt == CW'(WIDTH-1)) || (!is_div && (opb[WIDTH-1:1] == '0));
`else
  assign run_last = (cnt == CW'(WIDTH-1));
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PREP;
      PREP:    state_nx = (is_div && div_zero) ? FIX : RUN;
      RUN:     if (run_last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      flag_z  <= 1'b0;
      flag_dz <= 1'b0;
    end else begin
      done <= (state == FIX) && !flush;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q <= op;
            a_q  <= op1;
            b_q  <= op2;
          end
        end
        PREP: begin
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dz_q  <= is_div & div_zero;
          cnt   <= '0;
          acc   <= '0;
          if (is_div) begin
            opa <= {{WIDTH{1'b0}}, b_mag};
            opb <= a_mag;
          end else begin
            opa <= {{WIDTH{1'b0}}, a_mag};
            opb <= b_mag;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]};
            opb <= {opb[WIDTH-2:0], q_bit};
          end else begin
            acc <= acc_add;
            opa <= opa << 1;
            opb <= opb >> 1;
          end
        end
        FIX: begin
          if (!flush) begin
            flag_dz <= dz_q;
            if (dz_q) begin
              hi     <= a_q;
              lo     <= '1;
              flag_z <= 1'b0;
            end else if (is_div) begin
              hi     <= rem_fix;
              lo     <= quot_fix;
              flag_z <= (quot_fix == '0);
            end else begin
              hi     <= prod_fix[2*WIDTH-1:WIDTH];
              lo     <= prod_fix[WIDTH-1:0];
              flag_z <= (prod_fix[WIDTH-1:0] == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit: directed + randomized bench with a cycle-level arithmetic model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start, flush;
  logic [1:0]  op;
  logic [31:0] op1, op2;
  logic        busy, done, flag_z, flag_dz;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .flag_z(flag_z), .flag_dz(flag_dz)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msb_idx(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // Architectural result and latency of one operation, from plain arithmetic.
  task automatic model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rhi, output logic [31:0] rlo,
                              output logic rdz, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] mag;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    rdz = 1'b0;
    lat = 34;
    case (o)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; rhi = p[63:32]; rlo = p[31:0]; end
      2'b01: begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rhi = a; rlo = 32'hFFFF_FFFF; rdz = 1'b1; lat = 2;
        end else if (o == 2'b10) begin
          rlo = a / b; rhi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          rlo = q[31:0]; rhi = r[31:0];
        end
      end
    endcase
`ifdef MDU_EARLY_OUT_EN
    if (!o[1]) begin
      mag = (o[0] && b[31]) ? -b : b;
      lat = 3 + msb_idx(mag);
    end
`endif
  endtask

  // Cycle-level model: pending result plus remaining-cycle countdown.
  logic        m_busy, m_done, m_z, m_dz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_dz;
  int          m_cnt, p_lat;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy = 0; m_done = 0; m_z = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (flush) m_busy = 0;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 0; m_done = 1;
            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_z = (p_lo == 32'd0);
          end
        end
      end else if (start && !flush) begin
        model_result(op, op1, op2, p_hi, p_lo, p_dz, p_lat);
        m_busy = 1;
        m_cnt  = p_lat;
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("flag_z", flag_z, m_z);
      chk("flag_dz", flag_dz, m_dz);
    end
  end

  // Called just after a clock edge in a cycle where busy is low.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bc);
    start = 1; op = o; op1 = a; op2 = b;
    @(posedge CLK); #1;
    start = 0; op1 = $urandom; op2 = $urandom;
    chk("busy_after_accept", busy, 1);
    lat = -1;
    bc  = busy ? 1 : 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge CLK); #1;
      if (done) begin lat = n; break; end
      bc += busy ? 1 : 0;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  int lat, bc;

  initial begin
    nRST = 0; start = 0; flush = 0; op = 0; op1 = 0; op2 = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_flags", {flag_z, flag_dz}, 0);
    #2 nRST = 1;
    @(posedge CLK); #1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);
    chk("multu_max_lat", lat, 34);
    chk("multu_max_busy_cycles", bc, 34);

    do_op(2'b01, -32'd3, 32'd7, lat, bc);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFEB);
    chk("mult_neg_z", flag_z, 0);

    do_op(2'b11, -32'd7, 32'd2, lat, bc);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    chk("div_ovf_dz", flag_dz, 0);

    do_op(2'b10, 32'd100, 32'd0, lat, bc);
    chk("divu_dz_lat", lat, 2);
    chk("divu_dz_lo", lo, 32'hFFFF_FFFF);
    chk("divu_dz_hi", hi, 32'h64);
    chk("divu_dz_flag", flag_dz, 1);
    do_op(2'b10, 32'd0, 32'd5, lat, bc);
    chk("divu_zero_lo", lo, 32'h0);
    chk("divu_zero_hi", hi, 32'h0);
    chk("divu_zero_z", flag_z, 1);
    chk("divu_zero_dz", flag_dz, 0);

    // Asynchronous reset in the middle of a multiply.
    start = 1; op = 2'b00; op1 = 32'd9; op2 = 32'd9;
    @(posedge CLK); #1 start = 0;
    repeat (5) @(posedge CLK);
    #2 nRST = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_z", flag_z, 0);
    chk("rst_mid_lo", lo, 0);
    #3 nRST = 1;
    @(posedge CLK); #1;

    do_op(2'b00, 32'd4, 32'd5, lat, bc);
    chk("multu_4x5_lo", lo, 32'h14);
    start = 1; op = 2'b00; op1 = 32'd6; op2 = 32'd7;
    @(posedge CLK); #1 start = 0;
    repeat (9) @(posedge CLK);
    #1 flush = 1;
    @(posedge CLK); #1;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_lo_kept", lo, 32'h14);
    start = 1;
    @(posedge CLK); #1;
    chk("flush_start_dropped", busy, 0);
    start = 0; flush = 0;
    @(posedge CLK); #1;
    chk("flush_still_idle", busy, 0);
    do_op(2'b00, 32'd6, 32'd7, lat, bc);
    chk("multu_6x7_lo", lo, 32'h2A);

    // Second call starts in the done cycle of the first.
    do_op(2'b00, 32'd3, 32'd5, lat, bc);
    chk("multu_3x5_lo", lo, 32'd15);
`ifdef MDU_EARLY_OUT_EN
    chk("multu_3x5_lat", lat, 5);
`else
    chk("multu_3x5_lat", lat, 34);
`endif
    do_op(2'b01, -32'd4, -32'd6, lat, bc);
    chk("mult_b2b_lo", lo, 32'd24);
    chk("mult_b2b_hi", hi, 32'd0);

    for (int c = 0; c < 15000; c++) begin
      start = ($urandom_range(0, 3) != 0);
      op    = 2'($urandom_range(0, 3));
      op1   = rand_val();
      op2   = rand_val();
      flush = ($urandom_range(0, 149) == 0);
      @(posedge CLK); #1;
    end
    start = 0; flush = 0;
    repeat (40) @(posedge CLK);
    #1;
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
